// File: rtl/uart_boot_loader_pkg.sv
// rtl/uart_boot_loader_pkg.sv - shared state encodings and frame constants for the UART boot loader
package uart_boot_loader_pkg;

  // Frame-level states of the boot loader
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  // Bit-level states of the byte receiver
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [1:0] LANE_LAST     = 2'd3;
  localparam logic [2:0] BIT_LAST      = 3'd7;

endpackage

// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - RAM write port and boot status bundle driven by the loader
interface uart_boot_loader_if #(
  parameter int ADDR_W = 14
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              boot_done;
  logic              boot_err;

  modport master (
    output mem_we, mem_addr, mem_wdata, cpu_hold, boot_done, boot_err
  );

  modport slave (
    input mem_we, mem_addr, mem_wdata, cpu_hold, boot_done, boot_err
  );
endinterface

// File: rtl/uart_boot_rx.sv
// rtl/uart_boot_rx.sv - 8N1 byte receiver with synchroniser, start-bit glitch rejection and framing check
module uart_boot_rx
  import uart_boot_loader_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLK_DIV - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_e        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Register stage: synchroniser chain idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timer: mid-start check, then one sample per bit period, then the stop bit
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    unique case (st_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          st_d  = RX_START;
          cnt_d = HALF_CNT;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            st_d = RX_IDLE;
          end else begin
            st_d  = RX_DATA;
            cnt_d = FULL_CNT;
            bit_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_CNT;
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          valid_d = 1'b1;
          data_d  = shift_q;
          ferr_d  = !sync2_q;
          st_d    = RX_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_data  = data_q;
  assign rx_ferr  = ferr_q;
endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - frame FSM, word assembler and checksum writing a UART image into program RAM
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int         CLK_DIV   = 104,
  parameter int         MEM_WORDS = 16384,
  parameter int         ADDR_W    = $clog2(MEM_WORDS),
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               uart_rx,
  uart_boot_loader_if.master bus
);
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_boot_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_err_q, boot_err_d;
  logic [15:0]       n_word;

  // State and output registers; reset abandons any partially assembled word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      boot_done_q <= boot_done_d;
      boot_err_q  <= boot_err_d;
    end
  end

  // Frame parser: one decision per received byte; a bad stop bit mid-frame aborts it
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    word_d      = word_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    boot_done_d = boot_done_q;
    boot_err_d  = boot_err_q;
    n_word      = {rx_data, len_lo_q};
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && !rx_ferr && rx_data == SYNC_BYTE) begin
          boot_err_d = 1'b0;
          addr_d     = '0;
          lane_d     = '0;
          csum_d     = '0;
          state_d    = ST_LEN0;
        end
      end
      ST_LEN0: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_d = ST_ERR;
          end else begin
            len_lo_d = rx_data;
            state_d  = ST_LEN1;
          end
        end
      end
      ST_LEN1: begin
        if (rx_valid) begin
          len_d = n_word;
          if (rx_ferr || 32'(n_word) > MEM_WORDS) state_d = ST_ERR;
          else if (n_word == 16'd0)               state_d = ST_CSUM;
          else                                    state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_d = ST_ERR;
          end else begin
            word_d = {rx_data, word_q[23:8]};
            csum_d = csum_q + rx_data;
            lane_d = lane_q + 2'd1;
            if (lane_q == LANE_LAST) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = {rx_data, word_q};
              addr_d      = addr_q + ADDR_W'(1);
              if (16'(addr_q) == len_q - 16'd1) state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          if (!rx_ferr && rx_data == csum_q) begin
            boot_done_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ERR) boot_err_d = 1'b1;
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = !boot_done_q;
  assign bus.boot_done = boot_done_q;
  assign bus.boot_err  = boot_err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for the UART boot loader with a frame-level reference model
module tb_uart_boot_loader;
  localparam int CLK_DIV   = 8;
  localparam int MEM_WORDS = 16384;
  localparam int ADDR_W    = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;

  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_boot_loader #(
    .CLK_DIV   (CLK_DIV),
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int rxv_count = 0;
  logic we_prev = 1'b0;

  // Reference model state: bytes of the frame in progress, sticky results, expected writes
  logic [7:0]         m_buf[$];
  bit                 m_done = 1'b0;
  bit                 m_err = 1'b0;
  logic [ADDR_W+31:0] exp_wr[$];
  logic [31:0]        obs_data[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    exp_wr.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  // Interpret the byte stream directly from the frame layout kept in m_buf
  task automatic model_byte(input logic [7:0] b);
    int sz;
    int n;
    logic [7:0] s;
    if (m_done) return;
    if (m_buf.size() == 0) begin
      if (b == 8'hA5) begin
        m_buf.push_back(b);
        m_err = 1'b0;
      end
      return;
    end
    m_buf.push_back(b);
    sz = m_buf.size();
    n = int'({m_buf[2], m_buf[1]});
    if (sz == 3) begin
      if (n > MEM_WORDS) begin
        m_err = 1'b1;
        m_buf.delete();
      end
      return;
    end
    if (sz <= 3 + 4 * n) begin
      if ((sz - 3) % 4 == 0)
        exp_wr.push_back({ADDR_W'((sz - 3) / 4 - 1), m_buf[sz-1], m_buf[sz-2], m_buf[sz-3], m_buf[sz-4]});
      return;
    end
    s = 8'd0;
    for (int i = 3; i < sz - 1; i++) s = s + m_buf[i];
    if (b == s) m_done = 1'b1;
    else        m_err  = 1'b1;
    m_buf.delete();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_boot_done"}, 32'(bus.boot_done), 32'(m_done));
    chk({tag, "_boot_err"},  32'(bus.boot_err),  32'(m_err));
    chk({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'(!m_done));
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (CLK_DIV + 6) @(negedge clk);
  endtask

  task automatic send_bytes(input string tag, input logic [7:0] q[$]);
    foreach (q[i]) begin
      send_byte(q[i]);
      check_status(tag);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    chk({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd1);
    chk({tag, "_boot_done"}, 32'(bus.boot_done), 32'd0);
    chk({tag, "_boot_err"},  32'(bus.boot_err),  32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    uart_rx = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values(tag);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    wr_count = 0;
    obs_data.delete();
  endtask

  // Compare process: every write strobe must match the next write the model predicts
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    if (bus.mem_we) begin
      wr_count++;
      obs_data.push_back(bus.mem_wdata);
      if (we_prev) chk("mem_we_single_pulse", 32'd1, 32'd0);
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e[ADDR_W+31:32]));
        chk("wr_data", bus.mem_wdata, e[31:0]);
      end
    end
    we_prev = bus.mem_we;
  end

  always @(posedge clk) if (dut.rx_valid) rxv_count++;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] frame1[$];
    logic [7:0] frame_bad[$];
    logic [7:0] b;
    int rxv_before;

    frame1 = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    frame_bad = frame1;
    frame_bad[11] = 8'h4D;

    repeat (2) @(negedge clk);

    // 1: good two-word frame
    do_reset("t1_reset");
    send_bytes("t1", frame1);
    chk("t1_write_count", 32'(wr_count), 32'd2);
    chk("t1_word0", obs_data.size() > 0 ? obs_data[0] : 32'hx, 32'h12345678);
    chk("t1_word1", obs_data.size() > 1 ? obs_data[1] : 32'hx, 32'hDEADBEEF);
    chk("t1_pending_writes", 32'(exp_wr.size()), 32'd0);
    chk("t1_done_literal", 32'(bus.boot_done), 32'd1);
    chk("t1_hold_literal", 32'(bus.cpu_hold), 32'd0);

    // 2: bad checksum, then the good frame again
    do_reset("t2_reset");
    send_bytes("t2_bad", frame_bad);
    chk("t2_err_literal", 32'(bus.boot_err), 32'd1);
    chk("t2_hold_literal", 32'(bus.cpu_hold), 32'd1);
    chk("t2_bad_write_count", 32'(wr_count), 32'd2);
    send_byte(frame1[0]);
    chk("t2_sync_clears_err", 32'(bus.boot_err), 32'd0);
    frame_bad = frame1[1:11];
    send_bytes("t2_good", frame_bad);
    chk("t2_done_literal", 32'(bus.boot_done), 32'd1);
    chk("t2_total_writes", 32'(wr_count), 32'd4);

    // 3: noise bytes and a one-clock glitch before the frame
    do_reset("t3_reset");
    send_bytes("t3_noise", '{8'h00, 8'hFF});
    rxv_before = rxv_count;
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    chk("t3_glitch_no_rx_valid", 32'(rxv_count - rxv_before), 32'd0);
    check_status("t3_glitch");
    send_bytes("t3", frame1);
    chk("t3_write_count", 32'(wr_count), 32'd2);
    chk("t3_done_literal", 32'(bus.boot_done), 32'd1);

    // 4: length just over the RAM depth
    do_reset("t4_reset");
    send_bytes("t4", '{8'hA5, 8'h01, 8'h40});
    chk("t4_err_literal", 32'(bus.boot_err), 32'd1);
    chk("t4_write_count", 32'(wr_count), 32'd0);

    // 5: reset during the third data byte, then a fresh frame
    do_reset("t5_reset");
    send_bytes("t5_head", '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56});
    b = 8'h34;
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("t5_mid_reset");
    uart_rx = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * CLK_DIV) @(negedge clk);
    chk("t5_no_partial_write", 32'(wr_count), 32'd0);
    send_bytes("t5", frame1);
    chk("t5_write_count", 32'(wr_count), 32'd2);
    chk("t5_word0", obs_data.size() > 0 ? obs_data[0] : 32'hx, 32'h12345678);

    // 6: empty image, then later bytes are ignored
    do_reset("t6_reset");
    send_bytes("t6_empty", '{8'hA5, 8'h00, 8'h00, 8'h00});
    chk("t6_done_literal", 32'(bus.boot_done), 32'd1);
    send_bytes("t6_after", frame1);
    chk("t6_write_count", 32'(wr_count), 32'd0);
    chk("t6_pending_writes", 32'(exp_wr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
